// File: rtl/cache_mem_arbiter_if.sv
// Cache-to-memory bus bundle for the cache/RAM arbiter.
//
// Handshake: a cache raises its request (iREN, or dREN/dWEN) together with
// its address and store data, and holds all of them stable until the
// matching wait line drops to 0 for exactly one cycle; load data is valid
// only in that cycle. Dropping the request before then withdraws it with no
// completion. The RAM side is a level interface: enables, address and store
// data are held while ramstate reports FREE/BUSY/ERROR, and the access
// completes in the cycle ramstate reads ACCESS.
interface cache_mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;

  // Arbiter view: serves cache requests, drives the RAM.
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  // Environment view: caches plus RAM.
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Memory-side responder for the instruction and data caches. Serves one
// access at a time on a single-ported RAM, with an IDLE cycle between any
// two grants. Data accesses win by default, but after STARVE_MAX
// consecutive data grants taken while a fetch was waiting, the next grant
// goes to the instruction side. STARVE_MAX must lie in 1..7 (3-bit counter).
module cache_mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                nRST,
  cache_mem_arbiter_if.slave  bus,
  output logic [1:0]          dbg_state,
  output logic [2:0]          dbg_starve_cnt
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] IACC = 2'd1;
  localparam logic [1:0] DACC = 2'd2;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [1:0] state;
  logic [1:0] next_state;
  logic [2:0] starve_cnt;
  logic [2:0] next_starve_cnt;
  logic       d_req;

  assign d_req          = bus.dREN | bus.dWEN;
  assign dbg_state      = state;
  assign dbg_starve_cnt = starve_cnt;

  // State and starvation counter; reset abandons any RAM access at once.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= next_state;
      starve_cnt <= next_starve_cnt;
    end
  end

  // Grant decision, RAM drive and completion pulses, all from current state.
  always_comb begin
    next_state      = state;
    next_starve_cnt = starve_cnt;
    bus.iwait       = 1'b1;
    bus.dwait       = 1'b1;
    bus.iload       = '0;
    bus.dload       = '0;
    bus.ramREN      = 1'b0;
    bus.ramWEN      = 1'b0;
    bus.ramaddr     = '0;
    bus.ramstore    = '0;
    case (state)
      IDLE: begin
        if (d_req && (!bus.iREN || (starve_cnt < STARVE_LIM))) begin
          next_state = DACC;
          // Only data grants that overtake a waiting fetch count as starving.
          if (bus.iREN) next_starve_cnt = starve_cnt + 3'd1;
        end else if (bus.iREN) begin
          next_state      = IACC;
          next_starve_cnt = '0;
        end
      end
      IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        // A withdrawn fetch never completes, even if the RAM answers now.
        if (!bus.iREN) begin
          next_state = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          bus.iwait  = 1'b0;
          bus.iload  = bus.ramload;
          next_state = IDLE;
        end
      end
      DACC: begin
        // Write takes priority when the cache raises both enables.
        if (bus.dWEN) begin
          bus.ramWEN   = 1'b1;
          bus.ramstore = bus.dstore;
        end else begin
          bus.ramREN = 1'b1;
        end
        bus.ramaddr = bus.daddr;
        if (!d_req) begin
          next_state = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          bus.dwait  = 1'b0;
          bus.dload  = bus.dWEN ? 32'd0 : bus.ramload;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios for reset, single fetch,
// write priority, starvation order, withdrawal and ERROR retry, then a
// randomized concurrent icache/dcache phase against a RAM model.
module tb_cache_mem_arbiter;

  localparam int unsigned STARVE = 4;
  localparam logic [1:0] R_FREE   = 2'd0;
  localparam logic [1:0] R_BUSY   = 2'd1;
  localparam logic [1:0] R_ACCESS = 2'd2;
  localparam logic [1:0] R_ERROR  = 2'd3;

  logic       CLK;
  logic       nRST;
  logic [1:0] dbg_state;
  logic [2:0] dbg_starve_cnt;

  cache_mem_arbiter_if bus ();

  cache_mem_arbiter #(.STARVE_MAX(STARVE)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .bus            (bus),
    .dbg_state      (dbg_state),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int vectors;
  int miscompares;
  int i_done;
  int d_done;
  logic [31:0] i_exp_q[$];
  logic [31:0] d_exp_q[$];
  logic        grant_log[$];   // 1 = data grant, 0 = instruction grant
  logic        en_prev;
  logic [31:0] ref_d [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Initial RAM contents for never-written words.
  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // ---------------- RAM model ----------------
  int          ram_lat;
  int          ram_err;
  bit          ram_rand;
  bit          ram_busy;
  int          cur_lat;
  int          cur_err;
  int          ram_cnt;
  logic [31:0] ram_mem [logic [31:0]];

  always @(negedge CLK) begin
    if (bus.ramREN || bus.ramWEN) begin
      if (!ram_busy) begin
        ram_busy = 1'b1;
        ram_cnt  = 0;
        if (ram_rand) begin
          cur_lat = int'($urandom_range(0, 3));
          cur_err = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0;
        end else begin
          cur_lat = ram_lat;
          cur_err = ram_err;
        end
      end
      if (cur_err > 0) begin
        bus.ramstate = R_ERROR;
        bus.ramload  = $urandom;
        cur_err--;
      end else if (ram_cnt < cur_lat) begin
        bus.ramstate = R_BUSY;
        bus.ramload  = $urandom;
        ram_cnt++;
      end else begin
        bus.ramstate = R_ACCESS;
        if (bus.ramWEN) begin
          ram_mem[bus.ramaddr] = bus.ramstore;
          bus.ramload = $urandom;
        end else begin
          bus.ramload = ram_mem.exists(bus.ramaddr) ? ram_mem[bus.ramaddr] : pat(bus.ramaddr);
        end
        ram_busy = 1'b0;
      end
    end else begin
      bus.ramstate = R_FREE;
      bus.ramload  = $urandom;
      ram_busy     = 1'b0;
    end
  end

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    #1;
    chk("waits_both_low", {31'd0, (!bus.iwait && !bus.dwait)}, 32'd0);
    chk("ram_en_both_high", {31'd0, (bus.ramREN && bus.ramWEN)}, 32'd0);
    if (!bus.iwait) begin
      i_done++;
      if (i_exp_q.size() == 0) chk("iwait_unexpected_pulse", 32'd1, 32'd0);
      else chk("iload", bus.iload, i_exp_q.pop_front());
    end else begin
      chk("iload_idle_zero", bus.iload, 32'd0);
    end
    if (!bus.dwait) begin
      d_done++;
      if (d_exp_q.size() == 0) chk("dwait_unexpected_pulse", 32'd1, 32'd0);
      else chk("dload", bus.dload, d_exp_q.pop_front());
    end else begin
      chk("dload_idle_zero", bus.dload, 32'd0);
    end
    if ((bus.ramREN || bus.ramWEN) && !en_prev) grant_log.push_back(bus.ramaddr[13]);
    en_prev = bus.ramREN || bus.ramWEN;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic i_fetch(input logic [31:0] a, input logic [31:0] exp);
    int d0;
    int n;
    d0 = i_done;
    n  = 0;
    bus.iREN  = 1'b1;
    bus.iaddr = a;
    i_exp_q.push_back(exp);
    while (i_done == d0 && n < 300) begin
      tick();
      n++;
    end
    chk("i_fetch_done", {31'd0, (i_done != d0)}, 32'd1);
    if (i_done == d0) void'(i_exp_q.pop_back());
    next_cycle();
    bus.iREN = 1'b0;
  endtask

  task automatic d_access(input bit wr, input bit rd, input logic [31:0] a,
                          input logic [31:0] data, input logic [31:0] exp);
    int d0;
    int n;
    d0 = d_done;
    n  = 0;
    bus.dWEN   = wr;
    bus.dREN   = wr ? rd : 1'b1;
    bus.daddr  = a;
    bus.dstore = data;
    d_exp_q.push_back(exp);
    while (d_done == d0 && n < 300) begin
      tick();
      n++;
    end
    chk("d_access_done", {31'd0, (d_done != d0)}, 32'd1);
    if (d_done == d0) void'(d_exp_q.pop_back());
    next_cycle();
    bus.dWEN = 1'b0;
    bus.dREN = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int held;
    int base;
    logic [31:0] a;
    logic [31:0] v;
    vectors = 0; miscompares = 0; i_done = 0; d_done = 0;
    en_prev = 1'b0;
    ram_lat = 1; ram_err = 0; ram_rand = 1'b0; ram_busy = 1'b0;
    cur_lat = 0; cur_err = 0; ram_cnt = 0;
    bus.ramstate = R_FREE; bus.ramload = '0;
    // Requests driven during reset must not leak to any output.
    bus.iREN = 1'b1; bus.iaddr = 32'h1234; bus.dREN = 1'b1; bus.dWEN = 1'b1;
    bus.daddr = 32'h5678; bus.dstore = 32'hFFFF_0000;
    nRST = 1'b0;
    repeat (2) tick();
    chk("rst_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("rst_dwait", {31'd0, bus.dwait}, 32'd1);
    chk("rst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 32'd0);
    chk("rst_ramaddr", bus.ramaddr, 32'd0);
    chk("rst_ramstore", bus.ramstore, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    chk("rst_starve", {29'd0, dbg_starve_cnt}, 32'd0);
    next_cycle();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.iaddr = '0; bus.daddr = '0;
    bus.dstore = '0;
    nRST = 1'b1;

    // Reset in the middle of a fetch.
    ram_lat = 50;
    next_cycle();
    bus.iREN = 1'b1; bus.iaddr = 32'h1100;
    repeat (3) tick();
    chk("midacc_ramREN", {31'd0, bus.ramREN}, 32'd1);
    @(posedge CLK); #3;
    nRST = 1'b0;
    #1;
    chk("midrst_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("midrst_iwait", {31'd0, bus.iwait}, 32'd1);
    chk("midrst_dwait", {31'd0, bus.dwait}, 32'd1);
    next_cycle();
    ram_lat = 1;
    nRST = 1'b1;
    i_exp_q.push_back(pat(32'h1100));
    base = i_done;
    tick();
    chk("postrst_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("postrst_idle_state", {30'd0, dbg_state}, 32'd0);
    tick();
    chk("postrst_grant_ramREN", {31'd0, bus.ramREN}, 32'd1);
    n = 0;
    while (i_done == base && n < 20) begin tick(); n++; end
    chk("postrst_fetch_done", i_done - base, 32'd1);
    next_cycle();
    bus.iREN = 1'b0;

    // Single fetch: ACCESS two cycles after the enable.
    ram_mem[32'h40] = 32'hDEAD_BEEF;
    ram_lat = 2;
    next_cycle();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    i_exp_q.push_back(32'hDEAD_BEEF);
    base = i_done;
    tick();
    chk("fetch_idle_ramREN", {31'd0, bus.ramREN}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fetch_ramREN", {31'd0, bus.ramREN}, 32'd1);
      chk("fetch_ramaddr", bus.ramaddr, 32'h40);
      chk("fetch_iwait", {31'd0, bus.iwait}, (k == 2) ? 32'd0 : 32'd1);
    end
    next_cycle();
    bus.iREN = 1'b0;
    tick();
    chk("fetch_after_state", {30'd0, dbg_state}, 32'd0);
    chk("fetch_pulses", i_done - base, 32'd1);

    // Write wins over read; then read back through the RAM.
    ram_lat = 0;
    next_cycle();
    bus.dWEN = 1'b1; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'h1234;
    d_exp_q.push_back(32'd0);
    ref_d[32'h80] = 32'h1234;
    tick();
    tick();
    chk("wr_ramWEN", {31'd0, bus.ramWEN}, 32'd1);
    chk("wr_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("wr_ramstore", bus.ramstore, 32'h1234);
    chk("wr_ramaddr", bus.ramaddr, 32'h80);
    chk("wr_dwait", {31'd0, bus.dwait}, 32'd0);
    next_cycle();
    bus.dWEN = 1'b0; bus.dREN = 1'b0;
    d_access(1'b0, 1'b1, 32'h80, 32'd0, ref_d[32'h80]);

    // Both sides held continuously: every (STARVE+1)th grant goes to I.
    grant_log.delete();
    ram_lat = 0;
    base = i_done + d_done;
    for (int k = 0; k < 10; k++) begin
      if (k % (STARVE + 1) == STARVE) i_exp_q.push_back(pat(32'h1000));
      else d_exp_q.push_back(pat(32'h2000));
    end
    bus.iREN = 1'b1; bus.iaddr = 32'h1000;
    bus.dREN = 1'b1; bus.dWEN = 1'b0; bus.daddr = 32'h2000;
    n = 0;
    while ((i_done + d_done) < base + 10 && n < 200) begin tick(); n++; end
    next_cycle();
    bus.iREN = 1'b0; bus.dREN = 1'b0;
    chk("starve_grant_count", grant_log.size(), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < grant_log.size())
        chk("starve_grant_side", {31'd0, grant_log[k]},
            (k % (STARVE + 1) == STARVE) ? 32'd0 : 32'd1);
    end

    // Fetch withdrawn while the RAM is busy.
    ram_lat = 50;
    next_cycle();
    base = i_done;
    bus.iREN = 1'b1; bus.iaddr = 32'h1040;
    repeat (4) tick();
    next_cycle();
    bus.iREN = 1'b0;
    tick();
    tick();
    chk("withdraw_ramREN", {31'd0, bus.ramREN}, 32'd0);
    chk("withdraw_state", {30'd0, dbg_state}, 32'd0);
    chk("withdraw_no_pulse", i_done - base, 32'd0);

    // ERROR is retried until ACCESS, with one completion pulse.
    ram_lat = 0; ram_err = 5;
    next_cycle();
    base = d_done;
    bus.dREN = 1'b1; bus.daddr = 32'h2040;
    d_exp_q.push_back(pat(32'h2040));
    tick();
    held = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!bus.dwait) break;
      held++;
    end
    chk("error_hold_cycles", held, 32'd5);
    next_cycle();
    bus.dREN = 1'b0;
    ram_err = 0;
    tick();
    chk("error_single_pulse", d_done - base, 32'd1);

    // Randomized concurrent traffic.
    ram_rand = 1'b1;
    next_cycle();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) next_cycle();
          a = 32'h1000 + 32'(4 * $urandom_range(0, 63));
          i_fetch(a, pat(a));
        end
      end
      begin
        for (int k = 0; k < 40; k++) begin
          logic [31:0] da;
          logic [31:0] dv;
          repeat ($urandom_range(0, 3)) next_cycle();
          da = 32'h2000 + 32'(4 * $urandom_range(0, 15));
          if ($urandom_range(0, 1) == 1) begin
            dv = $urandom;
            ref_d[da] = dv;
            d_access(1'b1, 1'($urandom_range(0, 1)), da, dv, 32'd0);
          end else begin
            v = ref_d.exists(da) ? ref_d[da] : pat(da);
            d_access(1'b0, 1'b1, da, $urandom, v);
          end
        end
      end
    join
    ram_rand = 1'b0;
    repeat (3) tick();
    chk("i_queue_drained", i_exp_q.size(), 32'd0);
    chk("d_queue_drained", d_exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
